// File: rtl/core_seq_if.sv
// Fetch and load/store handshake bundle between core_seq and the IFU/LSU bus ports.
// The master side (the sequencer) raises requests; the slave side accepts and responds.
interface core_seq_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_err;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_err;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_err,
        input  ifu_rsp_data,
        output lsu_req_valid,
        input  lsu_req_ready,
        input  lsu_rsp_valid,
        input  lsu_rsp_err
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_err,
        output ifu_rsp_data,
        input  lsu_req_valid,
        output lsu_req_ready,
        output lsu_rsp_valid,
        output lsu_rsp_err
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle sequencer for the single-issue RV32 core: owns PC/IR, drives fetch and LSU handshakes,
// gates commits. Optional handshake timeout halt is built when CORE_SEQ_TIMEOUT_EN is defined.
module core_seq #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    core_seq_if.master  bus,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_ebreak,
    input  logic [31:0] next_pc,
    output logic        rf_we_en,
    output logic        csr_we_en,
    output logic        commit,
    output logic [31:0] inst_cnt,
    output logic        halt,
    output logic [1:0]  halt_code
);

    typedef enum logic [2:0] {
        RESET,
        FETCH_REQ,
        FETCH_WAIT,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    localparam logic [1:0] CODE_EBREAK  = 2'd0;
    localparam logic [1:0] CODE_IFU     = 2'd1;
    localparam logic [1:0] CODE_LSU     = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("core_seq: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state;
    state_t      state_next;
    logic [1:0]  halt_code_next;
    logic        load_inst;
    logic        timeout_hit;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TIMER_W-1:0] timer;
    logic               timed;

    assign timed = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                   (state == MEM_REQ)   || (state == MEM_WAIT);

    // The edge that would take the count to TIMEOUT_CYCLES is the one that halts.
    always_ff @(posedge clk) begin
        if (rst || (state_next != state)) begin
            timer <= '0;
        end else if (timed) begin
            timer <= timer + 1'b1;
        end
    end

    assign timeout_hit = timed && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET;
            pc        <= RESET_PC;
            inst      <= '0;
            inst_cnt  <= '0;
            halt_code <= CODE_EBREAK;
        end else begin
            state     <= state_next;
            halt_code <= halt_code_next;
            if (load_inst) begin
                inst <= bus.ifu_rsp_data;
            end
            if (state == WB) begin
                pc       <= next_pc;
                inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        halt_code_next = halt_code;
        load_inst      = 1'b0;
        case (state)
            RESET: begin
                state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (bus.ifu_req_ready) begin
                    state_next = FETCH_WAIT;
                end else if (timeout_hit) begin
                    state_next     = HALT;
                    halt_code_next = CODE_TIMEOUT;
                end
            end
            FETCH_WAIT: begin
                if (bus.ifu_rsp_valid) begin
                    if (bus.ifu_rsp_err) begin
                        state_next     = HALT;
                        halt_code_next = CODE_IFU;
                    end else begin
                        load_inst  = 1'b1;
                        state_next = EXEC;
                    end
                end else if (timeout_hit) begin
                    state_next     = HALT;
                    halt_code_next = CODE_TIMEOUT;
                end
            end
            EXEC: begin
                if (dec_ebreak) begin
                    state_next     = HALT;
                    halt_code_next = CODE_EBREAK;
                end else if (dec_is_load || dec_is_store) begin
                    state_next = MEM_REQ;
                end else begin
                    state_next = WB;
                end
            end
            MEM_REQ: begin
                if (bus.lsu_req_ready) begin
                    state_next = MEM_WAIT;
                end else if (timeout_hit) begin
                    state_next     = HALT;
                    halt_code_next = CODE_TIMEOUT;
                end
            end
            MEM_WAIT: begin
                if (bus.lsu_rsp_valid) begin
                    if (bus.lsu_rsp_err) begin
                        state_next     = HALT;
                        halt_code_next = CODE_LSU;
                    end else begin
                        state_next = WB;
                    end
                end else if (timeout_hit) begin
                    state_next     = HALT;
                    halt_code_next = CODE_TIMEOUT;
                end
            end
            WB: begin
                state_next = FETCH_REQ;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RESET;
            end
        endcase
    end

    assign bus.ifu_req_valid = (state == FETCH_REQ);
    assign bus.lsu_req_valid = (state == MEM_REQ);
    assign rf_we_en          = (state == WB);
    assign csr_we_en         = (state == WB);
    assign commit            = (state == WB);
    assign halt              = (state == HALT);

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq: ALU/load/store flows, halts, reset mid-handshake,
// and (when CORE_SEQ_TIMEOUT_EN is defined) the fetch timeout.
module tb_core_seq;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          TB_TIMEOUT = 8;

    localparam logic [31:0] I_ADDI   = 32'h0010_0093;
    localparam logic [31:0] I_ADD    = 32'h0020_81B3;
    localparam logic [31:0] I_SUB    = 32'h4020_8233;
    localparam logic [31:0] I_LW     = 32'h0000_A283;
    localparam logic [31:0] I_SW     = 32'h0050_A023;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_ebreak;
    logic [31:0] next_pc;
    logic        rf_we_en;
    logic        csr_we_en;
    logic        commit;
    logic [31:0] inst_cnt;
    logic        halt;
    logic [1:0]  halt_code;

    core_seq_if bus ();

    core_seq #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .inst         (inst),
        .pc           (pc),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_ebreak   (dec_ebreak),
        .next_pc      (next_pc),
        .rf_we_en     (rf_we_en),
        .csr_we_en    (csr_we_en),
        .commit       (commit),
        .inst_cnt     (inst_cnt),
        .halt         (halt),
        .halt_code    (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;
    int commit_cnt = 0;
    int rf_cnt     = 0;
    int csr_cnt    = 0;
    int lsu_cnt    = 0;
    int last_commit = 0;
    int prev_commit = 0;
    int last_rf     = 0;
    int t0          = 0;

    // Advance one cycle and sample the DUT 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (commit) begin
            commit_cnt++;
            prev_commit = last_commit;
            last_commit = cyc;
        end
        if (rf_we_en) begin
            rf_cnt++;
            last_rf = cyc;
        end
        if (csr_we_en) csr_cnt++;
        if (bus.lsu_req_valid) lsu_cnt++;
    endtask

    task automatic clearCounters();
        commit_cnt = 0;
        rf_cnt     = 0;
        csr_cnt    = 0;
        lsu_cnt    = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic eb, input logic [31:0] npc);
        dec_is_load  = ld;
        dec_is_store = st;
        dec_ebreak   = eb;
        next_pc      = npc;
    endtask

    // Hold reset two cycles, release it, and land in FETCH_REQ.
    task automatic doReset(input string tag);
        rst = 1'b1;
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_err   = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        bus.lsu_rsp_err   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        checkOutput({tag, "_rst_pc"},        pc,                        RESET_PC);
        checkOutput({tag, "_rst_inst"},      inst,                      32'h0);
        checkOutput({tag, "_rst_cnt"},       inst_cnt,                  32'h0);
        checkOutput({tag, "_rst_halt"},      {31'h0, halt},             32'h0);
        checkOutput({tag, "_rst_code"},      {30'h0, halt_code},        32'h0);
        checkOutput({tag, "_rst_ifu_valid"}, {31'h0, bus.ifu_req_valid}, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput({tag, "_first_ifu_valid"}, {31'h0, bus.ifu_req_valid}, 32'h1);
        checkOutput({tag, "_first_pc"},        pc,                          RESET_PC);
    endtask

    // Run one instruction from FETCH_REQ with zero-wait fetch; returns early if it halts.
    task automatic runInstr(input logic [31:0] word, input logic ld, input logic st, input logic eb,
                            input logic [31:0] npc, input int lreq_dly, input int lrsp_dly,
                            input logic ferr, input logic lerr);
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_err   = ferr;
        bus.ifu_rsp_data  = word;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_err   = 1'b0;
        if (ferr) return;
        applyStimulus(ld, st, eb, npc);
        tick();
        if (eb) return;
        if (ld || st) begin
            repeat (lreq_dly) tick();
            bus.lsu_req_ready = 1'b1;
            tick();
            bus.lsu_req_ready = 1'b0;
            repeat (lrsp_dly) tick();
            bus.lsu_rsp_valid = 1'b1;
            bus.lsu_rsp_err   = lerr;
            tick();
            bus.lsu_rsp_valid = 1'b0;
            bus.lsu_rsp_err   = 1'b0;
            if (lerr) return;
        end
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        bus.ifu_rsp_data = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Three ALU instructions, zero-wait memories.
        doReset("alu");
        clearCounters();
        t0 = cyc;
        runInstr(I_ADDI, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 0, 0, 1'b0, 1'b0);
        checkOutput("alu1_pc",          pc,               32'h8000_0004);
        checkOutput("alu1_inst",        inst,             I_ADDI);
        checkOutput("alu1_commit_time", last_commit - t0, 32'd3);
        runInstr(I_ADD, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 0, 0, 1'b0, 1'b0);
        checkOutput("alu2_pc",          pc,               32'h8000_0008);
        runInstr(I_SUB, 1'b0, 1'b0, 1'b0, 32'h8000_000C, 0, 0, 1'b0, 1'b0);
        checkOutput("alu3_pc",          pc,               32'h8000_000C);
        checkOutput("alu_inst_cnt",     inst_cnt,         32'd3);
        checkOutput("alu_commit_cnt",   commit_cnt,       32'd3);
        checkOutput("alu_commit_gap",   last_commit - prev_commit, 32'd4);
        checkOutput("alu_csr_cnt",      csr_cnt,          32'd3);

        // Load: request accepted after 2 stall cycles, response 3 cycles after the earliest slot.
        clearCounters();
        t0 = cyc;
        runInstr(I_LW, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 2, 3, 1'b0, 1'b0);
        checkOutput("ld_lsu_valid_cycles", lsu_cnt,      32'd3);
        checkOutput("ld_rf_pulses",        rf_cnt,       32'd1);
        checkOutput("ld_rf_time",          last_rf - t0, 32'd10);
        checkOutput("ld_pc",               pc,           32'h8000_0010);
        checkOutput("ld_inst_cnt",         inst_cnt,     32'd4);

        // ebreak decoded alongside a load: ebreak wins, no memory request, no commit.
        clearCounters();
        runInstr(I_EBREAK, 1'b1, 1'b0, 1'b1, 32'h8000_0014, 0, 0, 1'b0, 1'b0);
        checkOutput("eb_halt",     {31'h0, halt},      32'h1);
        checkOutput("eb_code",     {30'h0, halt_code}, 32'h0);
        checkOutput("eb_pc",       pc,                 32'h8000_0010);
        checkOutput("eb_inst_cnt", inst_cnt,           32'd4);
        bus.ifu_req_ready = 1'b1;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = I_ADD;
        bus.lsu_req_ready = 1'b1;
        bus.lsu_rsp_valid = 1'b1;
        repeat (3) tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        checkOutput("eb_sticky_halt", {31'h0, halt},            32'h1);
        checkOutput("eb_inst_kept",   inst,                     I_EBREAK);
        checkOutput("eb_pc_kept",     pc,                       32'h8000_0010);
        checkOutput("eb_commits",     commit_cnt,               32'd0);
        checkOutput("eb_lsu_valid",   lsu_cnt,                  32'd0);
        checkOutput("eb_ifu_valid",   {31'h0, bus.ifu_req_valid}, 32'h0);

        // Fetch fault on the second fetch.
        doReset("ferr");
        runInstr(I_ADDI, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 0, 0, 1'b0, 1'b0);
        runInstr(I_SW, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 0, 0, 1'b1, 1'b0);
        checkOutput("ferr_halt",     {31'h0, halt},      32'h1);
        checkOutput("ferr_code",     {30'h0, halt_code}, 32'h1);
        checkOutput("ferr_inst",     inst,               I_ADDI);
        checkOutput("ferr_inst_cnt", inst_cnt,           32'd1);
        checkOutput("ferr_pc",       pc,                 32'h8000_0004);

        // LSU fault on a store.
        doReset("lerr");
        clearCounters();
        runInstr(I_SW, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 0, 0, 1'b0, 1'b1);
        checkOutput("lerr_halt",     {31'h0, halt},      32'h1);
        checkOutput("lerr_code",     {30'h0, halt_code}, 32'h2);
        checkOutput("lerr_rf",       rf_cnt,             32'd0);
        checkOutput("lerr_pc",       pc,                 RESET_PC);
        checkOutput("lerr_inst_cnt", inst_cnt,           32'd0);

        // Reset while waiting on a load response; the late response must be dropped.
        doReset("mrst");
        clearCounters();
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = I_LW;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h8000_0004);
        tick();
        bus.lsu_req_ready = 1'b1;
        tick();
        bus.lsu_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("mrst_inst",      inst,                       32'h0);
        checkOutput("mrst_lsu_valid", {31'h0, bus.lsu_req_valid}, 32'h0);
        rst = 1'b0;
        bus.lsu_rsp_valid = 1'b1;
        tick();
        bus.lsu_rsp_valid = 1'b0;
        repeat (3) tick();
        checkOutput("mrst_pc",        pc,                         RESET_PC);
        checkOutput("mrst_inst_cnt",  inst_cnt,                   32'd0);
        checkOutput("mrst_rf",        rf_cnt,                     32'd0);
        checkOutput("mrst_ifu_valid", {31'h0, bus.ifu_req_valid}, 32'h1);
        checkOutput("mrst_halt",      {31'h0, halt},              32'h0);

`ifdef CORE_SEQ_TIMEOUT_EN
        // Fetch request never accepted: timeout halt 8 cycles after FETCH_REQ entry.
        doReset("tmo");
        t0 = cyc;
        for (int i = 0; i < 20 && !halt; i++) tick();
        checkOutput("tmo_halt", {31'h0, halt},      32'h1);
        checkOutput("tmo_code", {30'h0, halt_code}, 32'h3);
        checkOutput("tmo_time", cyc - t0,           32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
